// File: rtl/board_pkg.sv
// Shared types for the board status/IO controller.
package board_pkg;

  typedef enum logic [1:0] {
    MODE_OFF = 2'b00,
    MODE_ON  = 2'b01,
    MODE_HB  = 2'b10,
    MODE_PWM = 2'b11
  } led_mode_e;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-FF synchroniser, stability counter,
// debounced level and a single-cycle rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic btn_o,
  output logic rise_o
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic             stable;
  logic             rise;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= btn_i;
      sync <= meta;
      rise <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Pulse is registered alongside stable so it lines up with the 0->1 change.
        stable <= sync;
        rise   <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign btn_o  = stable;
  assign rise_o = rise;

endmodule

// File: rtl/board_status_ctrl.sv
// Board status/IO controller: debounced buttons, heartbeat and per-LED
// mode selection (off / static / heartbeat / PWM) with registered LED drive.
module board_status_ctrl
  import board_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 25_000_000,
  parameter int unsigned NUM_BTN         = 7,
  parameter int unsigned NUM_LED         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250_000,
  parameter int unsigned HEARTBEAT_W     = 23,
  parameter int unsigned PWM_W           = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_BTN-1:0]       btn_i,
  output logic [NUM_BTN-1:0]       btn_o,
  output logic [NUM_BTN-1:0]       btn_rise_o,
  input  logic [2*NUM_LED-1:0]     led_mode_i,
  input  logic [NUM_LED-1:0]       led_val_i,
  input  logic [PWM_W*NUM_LED-1:0] led_duty_i,
  output logic [NUM_LED-1:0]       led_o,
  output logic                     heartbeat_o
);

  if (CLK_FREQ == 0 || NUM_BTN == 0 || NUM_LED == 0 || DEBOUNCE_CYCLES == 0) begin : g_param_check
    $error("board_status_ctrl: CLK_FREQ, NUM_BTN, NUM_LED and DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .btn_i (btn_i[i]),
      .btn_o (btn_o[i]),
      .rise_o(btn_rise_o[i])
    );
  end

  logic [HEARTBEAT_W-1:0] hb_cnt;
  logic [PWM_W-1:0]       pwm_cnt;
  logic [NUM_LED-1:0]     led_next;
  led_mode_e              mode;

  // Free-running counters; never disturbed by LED mode changes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hb_cnt  <= '0;
      pwm_cnt <= '0;
    end else begin
      hb_cnt  <= hb_cnt + HEARTBEAT_W'(1);
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  assign heartbeat_o = hb_cnt[HEARTBEAT_W-1];

  always_comb begin
    led_next = '0;
    mode     = MODE_OFF;
    for (int unsigned k = 0; k < NUM_LED; k++) begin
      mode = led_mode_e'(led_mode_i[2*k +: 2]);
      case (mode)
        MODE_OFF: led_next[k] = 1'b0;
        MODE_ON:  led_next[k] = led_val_i[k];
        MODE_HB:  led_next[k] = heartbeat_o;
        MODE_PWM: led_next[k] = (pwm_cnt < led_duty_i[PWM_W*k +: PWM_W]);
        default:  led_next[k] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_o <= '0;
    end else begin
      led_o <= led_next;
    end
  end

endmodule

// File: tb/tb_board_status_ctrl.sv
// Directed self-checking bench for board_status_ctrl (small debounce/heartbeat/PWM sizes).
module tb_board_status_ctrl;

  localparam int unsigned NUM_BTN = 7;
  localparam int unsigned NUM_LED = 8;
  localparam int unsigned DEB     = 16;
  localparam int unsigned HBW     = 4;
  localparam int unsigned PWMW    = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [NUM_BTN-1:0]      btn_i;
  logic [NUM_BTN-1:0]      btn_o;
  logic [NUM_BTN-1:0]      btn_rise_o;
  logic [2*NUM_LED-1:0]    led_mode_i;
  logic [NUM_LED-1:0]      led_val_i;
  logic [PWMW*NUM_LED-1:0] led_duty_i;
  logic [NUM_LED-1:0]      led_o;
  logic                    heartbeat_o;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cyc     = 0;

  board_status_ctrl #(
    .CLK_FREQ       (25_000_000),
    .NUM_BTN        (NUM_BTN),
    .NUM_LED        (NUM_LED),
    .DEBOUNCE_CYCLES(DEB),
    .HEARTBEAT_W    (HBW),
    .PWM_W          (PWMW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .btn_i      (btn_i),
    .btn_o      (btn_o),
    .btn_rise_o (btn_rise_o),
    .led_mode_i (led_mode_i),
    .led_val_i  (led_val_i),
    .led_duty_i (led_duty_i),
    .led_o      (led_o),
    .heartbeat_o(heartbeat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Heartbeat MSB after cyc edges since reset release.
  function automatic logic hb_at(input int unsigned c);
    logic [31:0] v;
    v = c;
    return v[HBW-1];
  endfunction

  task automatic test_reset();
    rst_ni     = 1'b0;
    btn_i      = '0;
    led_mode_i = '0;
    led_val_i  = '0;
    led_duty_i = '0;
    repeat (3) tick();
    rst_ni = 1'b1;
    cyc    = 0;
    btn_i[0]        = 1'b1;
    led_mode_i[1:0] = 2'b01;
    led_val_i[0]    = 1'b1;
    led_mode_i[3:2] = 2'b10;
    led_mode_i[5:4] = 2'b11;
    led_duty_i[2*PWMW +: PWMW] = 4'd8;
    repeat (30) tick();
    vectors++;
    if (btn_o[0] !== 1'b1 || led_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_active: btn_o=%b led_o=%b, need btn_o[0]=1 led_o[0]=1", btn_o, led_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if (btn_o !== '0 || btn_rise_o !== '0 || led_o !== '0 || heartbeat_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: btn_o=%b rise=%b led_o=%b hb=%b, need all 0", btn_o, btn_rise_o, led_o, heartbeat_o);
    end
    repeat (3) tick();
    vectors++;
    if (btn_o !== '0 || btn_rise_o !== '0 || led_o !== '0 || heartbeat_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: btn_o=%b rise=%b led_o=%b hb=%b, need all 0", btn_o, btn_rise_o, led_o, heartbeat_o);
    end
    led_mode_i = '0;
    rst_ni = 1'b1;
    cyc    = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      vectors++;
      if (heartbeat_o !== hb_at(cyc)) begin
        errors++;
        $display("FAIL hb_after_reset step %0d: got %b want %b", i, heartbeat_o, hb_at(cyc));
      end
      vectors++;
      if (btn_o[0] !== (i >= 18) || btn_rise_o[0] !== (i == 18)) begin
        errors++;
        $display("FAIL held_through_reset step %0d: btn=%b rise=%b want btn=%b rise=%b",
                 i, btn_o[0], btn_rise_o[0], (i >= 18), (i == 18));
      end
    end
    btn_i[0] = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_clean_press();
    btn_i[0] = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      vectors++;
      if (btn_o[0] !== (i >= 18) || btn_rise_o[0] !== (i == 18)) begin
        errors++;
        $display("FAIL press step %0d: btn=%b rise=%b want btn=%b rise=%b",
                 i, btn_o[0], btn_rise_o[0], (i >= 18), (i == 18));
      end
    end
    btn_i[0] = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      vectors++;
      if (btn_o[0] !== (i < 18) || btn_rise_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL release step %0d: btn=%b rise=%b want btn=%b rise=0",
                 i, btn_o[0], btn_rise_o[0], (i < 18));
      end
    end
  endtask

  task automatic test_bounce();
    int unsigned rises = 0;
    for (int p = 0; p < 3; p++) begin
      btn_i[1] = 1'b1;
      repeat (10) begin
        tick();
        vectors++;
        if (btn_o[1] !== 1'b0 || btn_rise_o[1] !== 1'b0) begin
          errors++;
          $display("FAIL bounce_high phase %0d: btn=%b rise=%b want 0 0", p, btn_o[1], btn_rise_o[1]);
        end
      end
      btn_i[1] = 1'b0;
      repeat (3) begin
        tick();
        vectors++;
        if (btn_o[1] !== 1'b0 || btn_rise_o[1] !== 1'b0) begin
          errors++;
          $display("FAIL bounce_low phase %0d: btn=%b rise=%b want 0 0", p, btn_o[1], btn_rise_o[1]);
        end
      end
    end
    btn_i[1] = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (btn_rise_o[1] === 1'b1) rises++;
      vectors++;
      if (btn_o[1] !== (i >= 18) || btn_rise_o[1] !== (i == 18)) begin
        errors++;
        $display("FAIL bounce_settle step %0d: btn=%b rise=%b want btn=%b rise=%b",
                 i, btn_o[1], btn_rise_o[1], (i >= 18), (i == 18));
      end
    end
    vectors++;
    if (rises != 1) begin
      errors++;
      $display("FAIL bounce_rise_count: got %0d want 1", rises);
    end
    btn_i[1] = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_pwm();
    logic [3:0] duties [3] = '{4'd0, 4'd4, 4'd15};
    logic [PWMW-1:0] pv;
    logic exp;
    int unsigned highs;
    led_mode_i[5:4] = 2'b11;
    for (int d = 0; d < 3; d++) begin
      led_duty_i[2*PWMW +: PWMW] = duties[d];
      highs = 0;
      for (int i = 0; i < 16; i++) begin
        tick();
        pv  = PWMW'(cyc - 1);
        exp = (pv < duties[d]);
        if (led_o[2] === 1'b1) highs++;
        vectors++;
        if (led_o[2] !== exp) begin
          errors++;
          $display("FAIL pwm duty %0d cnt %0d: got %b want %b", duties[d], pv, led_o[2], exp);
        end
      end
      vectors++;
      if (highs != 32'(duties[d])) begin
        errors++;
        $display("FAIL pwm_high_count duty %0d: got %0d want %0d", duties[d], highs, duties[d]);
      end
    end
    led_mode_i[5:4] = 2'b00;
    tick();
  endtask

  task automatic test_mode_switch();
    led_mode_i[7:6] = 2'b01;
    led_val_i[3]    = 1'b1;
    vectors++;
    if (led_o[3] !== 1'b0) begin
      errors++;
      $display("FAIL mode_on_pre: got %b want 0", led_o[3]);
    end
    tick();
    vectors++;
    if (led_o[3] !== 1'b1 || heartbeat_o !== hb_at(cyc)) begin
      errors++;
      $display("FAIL mode_on: led=%b hb=%b want led=1 hb=%b", led_o[3], heartbeat_o, hb_at(cyc));
    end
    led_mode_i[7:6] = 2'b10;
    led_val_i[3]    = 1'b0;
    vectors++;
    if (led_o[3] !== 1'b1) begin
      errors++;
      $display("FAIL mode_hb_pre: got %b want 1", led_o[3]);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (led_o[3] !== hb_at(cyc - 1) || heartbeat_o !== hb_at(cyc)) begin
        errors++;
        $display("FAIL mode_hb step %0d: led=%b hb=%b want led=%b hb=%b",
                 i, led_o[3], heartbeat_o, hb_at(cyc - 1), hb_at(cyc));
      end
    end
    led_mode_i[7:6] = 2'b00;
    tick();
    vectors++;
    if (led_o[3] !== 1'b0 || heartbeat_o !== hb_at(cyc)) begin
      errors++;
      $display("FAIL mode_off: led=%b hb=%b want led=0 hb=%b", led_o[3], heartbeat_o, hb_at(cyc));
    end
  endtask

  task automatic test_independence();
    int unsigned r0 = 0;
    int unsigned r6 = 0;
    logic p6;
    for (int s = 0; s < 36; s++) begin
      p6 = !((s >= 5 && s <= 6) || s == 13);
      btn_i[0] = 1'b1;
      btn_i[6] = p6;
      tick();
      if (btn_rise_o[0] === 1'b1) r0++;
      if (btn_rise_o[6] === 1'b1) r6++;
      vectors++;
      if (btn_o[0] !== (s >= 17) || btn_rise_o[0] !== (s == 17)) begin
        errors++;
        $display("FAIL indep_btn0 step %0d: btn=%b rise=%b want btn=%b rise=%b",
                 s, btn_o[0], btn_rise_o[0], (s >= 17), (s == 17));
      end
      vectors++;
      if (btn_o[6] !== (s >= 31) || btn_rise_o[6] !== (s == 31)) begin
        errors++;
        $display("FAIL indep_btn6 step %0d: btn=%b rise=%b want btn=%b rise=%b",
                 s, btn_o[6], btn_rise_o[6], (s >= 31), (s == 31));
      end
      vectors++;
      if (btn_o[5:1] !== 5'b0) begin
        errors++;
        $display("FAIL indep_others step %0d: got %b want 00000", s, btn_o[5:1]);
      end
    end
    vectors++;
    if (r0 != 1 || r6 != 1) begin
      errors++;
      $display("FAIL indep_rise_count: btn0=%0d btn6=%0d want 1 1", r0, r6);
    end
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_pwm();
    test_mode_switch();
    test_independence();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
